// File: rtl/writeback_unit.sv
// writeback_unit: the MEM/WB pipeline register. It selects the write-back
// source, aligns and extends load data, flags misaligned loads, and counts
// retired instructions.
module writeback_unit #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [XLEN-1:0]   mem_data_out,
    input  logic [XLEN-1:0]   alu_result_mem,
    input  logic [XLEN-1:0]   pc_plus4_mem,
    input  logic [XLEN-1:0]   csr_rdata_mem,
    input  logic [2:0]        funct3_mem,
    input  logic [3+RA_W:0]   control_word_mem,
    output logic              wb_valid,
    output logic              wb_rf_wb,
    output logic [RA_W-1:0]   wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_misaligned,
    output logic [CNT_W-1:0]  retire_count
);

    localparam int OFF_W = $clog2(XLEN / 8);

    // Control word fields: {rf_wb, wb_src[1:0], pc_src, rd}
    logic            rf_wb_in;
    logic [1:0]      wb_src_in;
    logic            pc_src_in;
    logic [RA_W-1:0] rd_in;

    assign rf_wb_in  = control_word_mem[RA_W+3];
    assign wb_src_in = control_word_mem[RA_W+2:RA_W+1];
    assign pc_src_in = control_word_mem[RA_W];
    assign rd_in     = control_word_mem[RA_W-1:0];

    logic [OFF_W-1:0] off;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  load_data;
    logic             load_misaligned;
    logic             mis_in;
    logic [XLEN-1:0]  data_in;

    // The addressed lane is moved down to bit 0 once; every format then
    // just picks its low bits from there.
    assign off     = alu_result_mem[OFF_W-1:0];
    assign shifted = mem_data_out >> {off, 3'b000};

    // Load formatting and per-format alignment check
    always_comb begin
        load_data       = '0;
        load_misaligned = 1'b0;
        case (funct3_mem)
            3'b000: load_data = XLEN'($signed(shifted[7:0]));
            3'b001: begin
                load_data       = XLEN'($signed(shifted[15:0]));
                load_misaligned = off[0];
            end
            3'b010: begin
                load_data       = XLEN'($signed(shifted[31:0]));
                load_misaligned = |off[1:0];
            end
            3'b011: begin
                // LD exists only on a 64-bit datapath; otherwise it reads as 0
                if (XLEN == 64) begin
                    load_data       = shifted;
                    load_misaligned = |off;
                end
            end
            3'b100: load_data = XLEN'(shifted[7:0]);
            3'b101: begin
                load_data       = XLEN'(shifted[15:0]);
                load_misaligned = off[0];
            end
            3'b110: begin
                load_data       = XLEN'(shifted[31:0]);
                load_misaligned = |off[1:0];
            end
            default: load_data = '0;
        endcase
    end

    assign mis_in = load_misaligned && (wb_src_in == 2'b10);

    // Write-back source select; a misaligned load writes zero
    always_comb begin
        data_in = '0;
        case (wb_src_in)
            2'b00:   data_in = alu_result_mem;
            2'b01:   data_in = pc_plus4_mem;
            2'b10:   data_in = mis_in ? '0 : load_data;
            default: data_in = csr_rdata_mem;
        endcase
    end

    logic             valid_q, valid_d;
    logic             rf_wb_q, rf_wb_d;
    logic [RA_W-1:0]  rd_q, rd_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic             mis_q, mis_d;
    logic             pc_src_unused_q, pc_src_unused_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             take;
    logic             live;

    // Flush forces a capture (of a bubble) even while stalled
    assign take = flush || !stall;
    assign live = in_valid && !flush;

    // Next-state: hold by default, capture when the stage advances
    always_comb begin
        valid_d         = valid_q;
        rf_wb_d         = rf_wb_q;
        rd_d            = rd_q;
        data_d          = data_q;
        mis_d           = mis_q;
        pc_src_unused_d = pc_src_unused_q;
        if (take) begin
            valid_d         = live;
            rf_wb_d         = live && rf_wb_in && (rd_in != '0) && !mis_in;
            rd_d            = rd_in;
            data_d          = data_in;
            mis_d           = live && mis_in;
            pc_src_unused_d = pc_src_in;
        end
        // The instruction in WB retires as it leaves, i.e. on an unstalled edge
        cnt_d = cnt_q;
        if (valid_q && !mis_q && !stall) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Stage registers and retire counter, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q         <= 1'b0;
            rf_wb_q         <= 1'b0;
            rd_q            <= '0;
            data_q          <= '0;
            mis_q           <= 1'b0;
            pc_src_unused_q <= 1'b0;
            cnt_q           <= '0;
        end else begin
            valid_q         <= valid_d;
            rf_wb_q         <= rf_wb_d;
            rd_q            <= rd_d;
            data_q          <= data_d;
            mis_q           <= mis_d;
            pc_src_unused_q <= pc_src_unused_d;
            cnt_q           <= cnt_d;
        end
    end

    assign wb_valid      = valid_q;
    assign wb_rf_wb      = rf_wb_q;
    assign wb_rd         = rd_q;
    assign wb_data       = data_q;
    assign wb_misaligned = mis_q;
    assign retire_count  = cnt_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit (XLEN=32): a vector table for the
// combinational formatting, then hand sequences for stall, flush, reset and
// counter wrap (second instance with a 4-bit counter).
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] mem_data_out = '0;
    logic [31:0] alu_result_mem = '0;
    logic [31:0] pc_plus4_mem = '0;
    logic [31:0] csr_rdata_mem = '0;
    logic [2:0]  funct3_mem = '0;
    logic [8:0]  control_word_mem = '0;

    logic        wb_valid, wb_rf_wb, wb_misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [63:0] retire_count;

    logic        w4_valid, w4_rf_wb, w4_misaligned;
    logic [4:0]  w4_rd;
    logic [31:0] w4_data;
    logic [3:0]  w4_count;

    writeback_unit #(.XLEN(32), .RA_W(5), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .mem_data_out(mem_data_out), .alu_result_mem(alu_result_mem),
        .pc_plus4_mem(pc_plus4_mem), .csr_rdata_mem(csr_rdata_mem),
        .funct3_mem(funct3_mem), .control_word_mem(control_word_mem),
        .wb_valid(wb_valid), .wb_rf_wb(wb_rf_wb), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_misaligned(wb_misaligned), .retire_count(retire_count)
    );

    writeback_unit #(.XLEN(32), .RA_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .mem_data_out(mem_data_out), .alu_result_mem(alu_result_mem),
        .pc_plus4_mem(pc_plus4_mem), .csr_rdata_mem(csr_rdata_mem),
        .funct3_mem(funct3_mem), .control_word_mem(control_word_mem),
        .wb_valid(w4_valid), .wb_rf_wb(w4_rf_wb), .wb_rd(w4_rd), .wb_data(w4_data),
        .wb_misaligned(w4_misaligned), .retire_count(w4_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [1:0]  src;
        logic        rf;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] mem;
        logic [31:0] pc4;
        logic [31:0] csr;
        logic        e_vld;
        logic        e_rf;
        logic        e_mis;
        logic [31:0] e_data;
    } vec_t;

    vec_t        vt[14];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [63:0] exp_cnt = '0;
    logic        m_valid = 1'b0;
    logic        m_mis = 1'b0;
    logic [63:0] cnt_before;

    function automatic vec_t mk(input logic vld, input logic [1:0] src, input logic rf,
                                input logic [4:0] rd, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] mem,
                                input logic [31:0] pc4, input logic [31:0] csr,
                                input logic e_vld, input logic e_rf, input logic e_mis,
                                input logic [31:0] e_data);
        vec_t v;
        v.vld = vld; v.src = src; v.rf = rf; v.rd = rd; v.f3 = f3;
        v.addr = addr; v.mem = mem; v.pc4 = pc4; v.csr = csr;
        v.e_vld = e_vld; v.e_rf = e_rf; v.e_mis = e_mis; v.e_data = e_data;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [1:0] src, input logic rf,
                         input logic pcs, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] mem,
                         input logic [31:0] pc4, input logic [31:0] csr);
        in_valid         = vld;
        control_word_mem = {rf, src, pcs, rd};
        funct3_mem       = f3;
        alu_result_mem   = addr;
        mem_data_out     = mem;
        pc_plus4_mem     = pc4;
        csr_rdata_mem    = csr;
    endtask

    // Reference counter: the instruction shown in WB retires on an unstalled edge
    task automatic tick();
        if (m_valid && !m_mis && !stall) exp_cnt = exp_cnt + 64'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {63'd0, wb_valid}, 64'd0);
        chk({tag, "_rf_wb"}, {63'd0, wb_rf_wb}, 64'd0);
        chk({tag, "_mis"}, {63'd0, wb_misaligned}, 64'd0);
        chk({tag, "_rd"}, {59'd0, wb_rd}, 64'd0);
        chk({tag, "_data"}, {32'd0, wb_data}, 64'd0);
        chk({tag, "_count"}, retire_count, 64'd0);
        chk({tag, "_count4"}, {60'd0, w4_count}, 64'd0);
    endtask

    initial begin
        vt[0]  = mk(1, 2'b10, 1, 5'd5,  3'b000, 32'h1003, 32'h80FF7F01, 0, 0,            1, 1, 0, 32'hFFFFFF80);
        vt[1]  = mk(1, 2'b10, 1, 5'd5,  3'b101, 32'h1002, 32'hBEEF1234, 0, 0,            1, 1, 0, 32'h0000BEEF);
        vt[2]  = mk(1, 2'b10, 1, 5'd5,  3'b001, 32'h1001, 32'hBEEF1234, 0, 0,            1, 0, 1, 32'h0);
        vt[3]  = mk(1, 2'b01, 1, 5'd0,  3'b000, 32'h0,    32'h0,        32'h104, 0,      1, 0, 0, 32'h104);
        vt[4]  = mk(1, 2'b00, 1, 5'd7,  3'b000, 32'h12345678, 32'h0,    0, 0,            1, 1, 0, 32'h12345678);
        vt[5]  = mk(1, 2'b11, 1, 5'd31, 3'b000, 32'h0,    32'h0,        0, 32'hCAFEF00D, 1, 1, 0, 32'hCAFEF00D);
        vt[6]  = mk(1, 2'b10, 1, 5'd5,  3'b100, 32'h2002, 32'h80FF7F01, 0, 0,            1, 1, 0, 32'h000000FF);
        vt[7]  = mk(1, 2'b10, 1, 5'd5,  3'b001, 32'h2002, 32'h80FF7F01, 0, 0,            1, 1, 0, 32'hFFFF80FF);
        vt[8]  = mk(1, 2'b10, 1, 5'd5,  3'b010, 32'h3000, 32'hDEADBEEF, 0, 0,            1, 1, 0, 32'hDEADBEEF);
        vt[9]  = mk(1, 2'b10, 1, 5'd5,  3'b010, 32'h3002, 32'hDEADBEEF, 0, 0,            1, 0, 1, 32'h0);
        vt[10] = mk(1, 2'b10, 1, 5'd5,  3'b111, 32'h3000, 32'hDEADBEEF, 0, 0,            1, 1, 0, 32'h0);
        vt[11] = mk(0, 2'b10, 1, 5'd5,  3'b001, 32'h1001, 32'hBEEF1234, 0, 0,            0, 0, 0, 32'h0);
        vt[12] = mk(1, 2'b10, 0, 5'd5,  3'b010, 32'h3000, 32'hDEADBEEF, 0, 0,            1, 0, 0, 32'hDEADBEEF);
        vt[13] = mk(1, 2'b00, 1, 5'd5,  3'b001, 32'h00000001, 32'h0,    0, 0,            1, 1, 0, 32'h00000001);

        // Asynchronous reset before any clock edge, then held across two edges
        #2 rst = 1'b1;
        #1 chk_all_zero("reset_async");
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_all_zero("reset_held");
        rst = 1'b0;

        // Table-driven formatting vectors
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].vld, vt[i].src, vt[i].rf, i[0], vt[i].rd, vt[i].f3,
                  vt[i].addr, vt[i].mem, vt[i].pc4, vt[i].csr);
            tick();
            chk($sformatf("v%0d_valid", i), {63'd0, wb_valid}, {63'd0, vt[i].e_vld});
            chk($sformatf("v%0d_rf_wb", i), {63'd0, wb_rf_wb}, {63'd0, vt[i].e_rf});
            chk($sformatf("v%0d_mis", i), {63'd0, wb_misaligned}, {63'd0, vt[i].e_mis});
            chk($sformatf("v%0d_rd", i), {59'd0, wb_rd}, {59'd0, vt[i].rd});
            chk($sformatf("v%0d_data", i), {32'd0, wb_data}, {32'd0, vt[i].e_data});
            chk($sformatf("v%0d_count", i), retire_count, exp_cnt);
            m_valid = vt[i].e_vld;
            m_mis   = vt[i].e_mis;
        end

        // Flush and stall together: flush wins, the held instruction is not counted
        drive(1, 2'b00, 1, 0, 5'd2, 3'b000, 32'h11, 0, 0, 0);
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("flush_stall_valid", {63'd0, wb_valid}, 64'd0);
        chk("flush_stall_rf_wb", {63'd0, wb_rf_wb}, 64'd0);
        chk("flush_stall_count", retire_count, exp_cnt);
        m_valid = 1'b0; m_mis = 1'b0;
        stall = 1'b0; flush = 1'b0;

        // Three-cycle stall on a valid instruction
        drive(1, 2'b00, 1, 0, 5'd3, 3'b000, 32'hAAAA0001, 0, 0, 0);
        tick();
        chk("stall_load_valid", {63'd0, wb_valid}, 64'd1);
        m_valid = 1'b1; m_mis = 1'b0;
        cnt_before = exp_cnt;
        stall = 1'b1;
        drive(1, 2'b00, 1, 0, 5'd9, 3'b000, 32'h55555555, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall%0d_valid", k), {63'd0, wb_valid}, 64'd1);
            chk($sformatf("stall%0d_data", k), {32'd0, wb_data}, 64'hAAAA0001);
            chk($sformatf("stall%0d_rd", k), {59'd0, wb_rd}, 64'd3);
            chk($sformatf("stall%0d_rf_wb", k), {63'd0, wb_rf_wb}, 64'd1);
            chk($sformatf("stall%0d_count", k), retire_count, cnt_before);
        end
        stall = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("stall_release_count", retire_count, cnt_before + 64'd1);
        chk("stall_release_valid", {63'd0, wb_valid}, 64'd0);
        m_valid = 1'b0;
        tick();
        chk("stall_after_count", retire_count, cnt_before + 64'd1);

        // Reset pulsed between edges while a valid instruction is held by stall
        drive(1, 2'b00, 1, 0, 5'd4, 3'b000, 32'h77, 0, 0, 0);
        tick();
        m_valid = 1'b1;
        stall = 1'b1;
        tick();
        chk("mid_stall_valid", {63'd0, wb_valid}, 64'd1);
        #2 rst = 1'b1;
        #1 chk_all_zero("reset_mid");
        rst = 1'b0;
        exp_cnt = '0; m_valid = 1'b0; m_mis = 1'b0;
        stall = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("post_reset_valid", {63'd0, wb_valid}, 64'd0);
        chk("post_reset_count", retire_count, exp_cnt);

        // First capture after reset, then 4-bit counter wrap
        rst = 1'b1;
        #1 rst = 1'b0;
        exp_cnt = '0; m_valid = 1'b0; m_mis = 1'b0;
        drive(1, 2'b00, 1, 0, 5'd1, 3'b000, 32'h1, 0, 0, 0);
        tick();
        chk("first_capture_valid", {63'd0, wb_valid}, 64'd1);
        chk("first_capture_data", {32'd0, wb_data}, 64'd1);
        m_valid = 1'b1;
        for (int k = 0; k < 15; k++) tick();
        chk("wrap_pre_count4", {60'd0, w4_count}, 64'd15);
        chk("wrap_pre_count", retire_count, exp_cnt);
        tick();
        chk("wrap_count4", {60'd0, w4_count}, 64'd0);
        chk("wrap_count", retire_count, exp_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
